pipe_stage_reg: RTL



---
 rtl/pipe_stage_reg.sv | 94 +++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage: main register plus optional skid entry; 1-cycle latency, full throughput.
// SKID=1 gives a registered s_ready (absorbs one extra entry); SKID=0 gives combinational s_ready.
module pipe_stage_reg #(
   parameter int unsigned      WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter bit               SKID      = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             s_valid,
   input  logic [WIDTH-1:0] s_data,
   output logic             s_ready,
   output logic             m_valid,
   output logic [WIDTH-1:0] m_data,
   input  logic             m_ready,
   output logic [1:0]       occupancy
);

   // Encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             in_xfer;
   logic             out_xfer;

   assign m_valid   = (state_q != EMPTY);
   assign m_data    = main_q;
   assign occupancy = state_q;
   assign in_xfer   = s_valid & s_ready;
   assign out_xfer  = m_valid & m_ready;

   generate
      if (SKID) begin : g_skid_rdy
         assign s_ready = (state_q != TWO);
      end else begin : g_comb_rdy
         assign s_ready = m_ready | ~m_valid;
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: begin
            if (in_xfer) begin
               state_d = ONE;
               main_d  = s_data;
            end
         end
         ONE: begin
            if (in_xfer && out_xfer) begin
               main_d = s_data;
            end else if (in_xfer && SKID) begin
               state_d = TWO;
               skid_d  = s_data;
            end else if (out_xfer) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (out_xfer) begin
               state_d = ONE;
               main_d  = skid_q;
            end
         end
         default: state_d = EMPTY;
      endcase
      // Flush only invalidates; payload registers keep whatever they captured.
      if (flush) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= EMPTY;
         main_q  <= RESET_VAL;
         skid_q  <= RESET_VAL;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

endmodule
